gate_sweep_checker: RTL
=======================

# gate_sweep_checker

Self-checking exhaustive stimulus engine for N-input combinational gates (CMOS AND/NAND/OR/NOR/XOR/XNOR cells). On `start` it walks every input pattern 0 … 2^N−1 onto the device under test, waits a programmable settle window per pattern, and compares the gate output against a built-in reference function. It reports pass/fail, a mismatch count, and the first failing vector. It sits beside any gate-level cell in the library, replacing hand-written per-cell pattern benches with one parametrised, synthesizable checker.

## Interface
Parameters:
- `N`, 3: gate input count; legal range 2..8.
- `SETTLE`, 1: extra hold cycles per pattern before sampling; legal range 1..15.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a sweep; sampled only in IDLE.
- `op` input 3: reference function, latched at start. 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6–7 illegal.
- `dut_out` input 1: gate output under test.
- `stim` output N: registered input vector driven to the gate.
- `busy` output 1: sweep in progress.
- `done` output 1: one-cycle pulse when results become valid.
- `pass` output 1: 1 if the completed sweep had zero mismatches and a legal op.
- `err_count` output N+1: mismatch count; range 0..2^N, so it never saturates.
- `first_fail` output N: vector of the first mismatch.
- `first_fail_valid` output 1: `first_fail` holds a real value.

## Operation
- Reset values of all outputs are 0: `stim`, `busy`, `done`, `pass`, `err_count`, `first_fail`, `first_fail_valid`.
- States:
  - IDLE: `start`=1 moves to RUN. On that edge the block latches `op`, clears `err_count`, `pass`, `first_fail` and `first_fail_valid`, sets `stim`=0, loads the settle counter, and sets `busy`=1.
  - RUN: the settle counter counts down. On the compare edge of each pattern the block checks `dut_out` against the reference for the current `stim`.
    - On mismatch it increments `err_count`. If `first_fail_valid`=0, it also captures `first_fail`=`stim` and sets `first_fail_valid`.
    - On that same edge `stim` advances by 1. After pattern 2^N−1 is compared, `stim` returns to 0 and the state moves to DONE.
  - DONE: lasts one cycle with `done`=1, `busy`=0, and `pass`=(`err_count`==0). Then the state returns to IDLE.
- Illegal op (6–7): the state goes IDLE→DONE directly. `busy` never rises, `pass`=0, `err_count`=0, `first_fail_valid`=0.
- `start` is ignored in RUN and DONE. Results hold from DONE until the next accepted `start`.
- Reference function: a reduction of `stim` per `op`.
- `rst_n` low at any time, including mid-sweep, forces all outputs and the state to reset values immediately. No partial results are retained.

## Timing
- Call the start edge edge 0; `stim`=0 is valid after it.
- Pattern k is held for SETTLE+1 cycles and compared at edge (k+1)·(SETTLE+1).
- Last compare edge: L = 2^N·(SETTLE+1). `busy` falls and `done`/`pass` rise after edge L.
- Examples: N=3, SETTLE=1 gives L=16. N=4, SETTLE=3 gives L=64.
- Illegal op: `done` is high in the cycle after edge 0.
- Combinational path: `stim` → gate → `dut_out` must settle within SETTLE+1 cycles.

## Structure
- Shared package `gate_sweep_pkg` holds:
  - op encoding constants (`OP_AND` … `OP_XNOR`);
  - the state enum `{IDLE, RUN, DONE}`;
  - a parameter-independent `op_legal(op)` function.
- Sub-module `gate_ref_eval #(N)`: combinational, (`op`, `vec`) → `expected`. It is reused by future cell-characterisation blocks.
- Top level contains the FSM, the settle counter (4 bits), the pattern register, and the result registers.

## Test plan
- N=3, SETTLE=1, correct AND3 model, `op`=0: `stim` steps 0→7 every 2 cycles, `done` at cycle 17, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- Same model with `op`=1 (NAND): every vector mismatches, so `err_count`=8, `first_fail`=3'b000, `pass`=0.
- AND3 model with output stuck at 0, `op`=0: `err_count`=1, `first_fail`=3'b111, `pass`=0.
- Pulse `start` again mid-sweep: it is ignored and timing is unchanged. A new `start` after DONE clears prior results at edge 0.
- `rst_n` low while `stim`=4: all outputs read 0 before the next edge. A fresh `start` runs the full 16-cycle sweep.
- `op`=6: `done` appears one cycle after start, `busy` stays 0, and `pass`=0. Repeat the AND-model run with N=4, SETTLE=3: `done` at cycle 65.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep checker: op encodings, FSM states,
// and an op legality helper usable by any block that accepts an op code.
package gate_sweep_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Combinational reference model of an N-input gate: reduces vec per op.
// Illegal ops evaluate to 0; callers are expected to reject them separately.
module gate_ref_eval
  import gate_sweep_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] vec,
  output logic         expected
);

  // NOTE: a default assignment at the top of every combinational block
  // guarantees each path drives the output, so no latch is inferred.
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = &vec;
      OP_NAND: expected = ~&vec;
      OP_OR:   expected = |vec;
      OP_NOR:  expected = ~|vec;
      OP_XOR:  expected = ^vec;
      OP_XNOR: expected = ~^vec;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive pattern sweep of an N-input gate with a programmable settle
// window, comparing against gate_ref_eval and reporting count/first failure.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         dut_out,
  output logic [N-1:0] stim,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail,
  output logic         first_fail_valid
);

  localparam logic [3:0]   SETTLE_LD = 4'(SETTLE);
  localparam logic [N-1:0] LAST_VEC  = {N{1'b1}};

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [3:0] settle_cnt;
  logic       expected;
  logic       compare_edge;
  logic       last_compare;
  logic       mismatch;

  gate_ref_eval #(.N(N)) u_ref (
    .op       (op_q),
    .vec      (stim),
    .expected (expected)
  );

  // A pattern is judged on the edge where its settle window has run out.
  assign compare_edge = (state == RUN) && (settle_cnt == 4'd0);
  assign last_compare = compare_edge && (stim == LAST_VEC);
  assign mismatch     = compare_edge && (dut_out != expected);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op_legal(op) ? RUN : DONE;
      RUN:     if (last_compare) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q             <= OP_AND;
      stim             <= '0;
      settle_cnt       <= 4'd0;
      err_count        <= '0;
      pass             <= 1'b0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == IDLE && start) begin
      op_q             <= op;
      stim             <= '0;
      settle_cnt       <= SETTLE_LD;
      err_count        <= '0;
      pass             <= 1'b0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == RUN) begin
      if (!compare_edge) begin
        settle_cnt <= settle_cnt - 4'd1;
      end else begin
        settle_cnt <= SETTLE_LD;
        stim       <= stim + N'(1);
        if (mismatch) begin
          err_count <= err_count + (N+1)'(1);
          if (!first_fail_valid) begin
            first_fail       <= stim;
            first_fail_valid <= 1'b1;
          end
        end
        // The final compare may itself add an error, so fold it into pass.
        if (last_compare) pass <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule
